// File: rtl/alu_cmd_driver.sv
// rtl/alu_cmd_driver.sv - command/response driver for the registered ALU wrapper
// Optional self-check of wrapper results enabled by defining ALU_CMD_DRIVER_CHECK_EN.
module alu_cmd_driver #(
  parameter int W       = 4,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  input  logic [2*W-1:0]   alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*W-1:0]   rsp_data,
  output logic [1:0]       rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic             mismatch
);

  localparam int WCW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WCW-1:0] wait_cnt;
  logic           accept;
  logic           capture;
  logic           complete;

  assign accept   = (state == IDLE) && cmd_valid;
  assign capture  = (state == WAIT) && (wait_cnt == '0);
  assign complete = (state == RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = WAIT;
      WAIT:    if (capture)  state_next = RESP;
      RESP:    if (complete) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // ALU inputs stay at the last accepted command; the wrapper samples them over several edges
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        alu_a    <= cmd_a;
        alu_b    <= cmd_b;
        alu_op   <= cmd_op;
        wait_cnt <= WCW'(LATENCY);
      end
      if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (capture) begin
        rsp_data  <= alu_out;
        rsp_op    <= alu_op;
        rsp_valid <= 1'b1;
      end
      if (complete) begin
        rsp_valid <= 1'b0;
        txn_count <= txn_count + 1'b1;
      end
    end
  end

`ifdef ALU_CMD_DRIVER_CHECK_EN
  logic [2*W-1:0] expected;

  always_comb begin
    expected = '0;
    case (alu_op)
      2'b00:   expected = {{W{1'b0}}, alu_a} + {{W{1'b0}}, alu_b};
      2'b01:   expected = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};
      2'b10:   expected = {{W{1'b0}}, alu_a | alu_b};
      default: expected = {{W{1'b0}}, alu_a & alu_b};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else if (capture && (alu_out != expected)) begin
      mismatch <= 1'b1;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb/tb_alu_cmd_driver.sv - self-checking bench for alu_cmd_driver with a 2-stage ALU wrapper model
// Expected mismatch behaviour follows ALU_CMD_DRIVER_CHECK_EN.
module tb_alu_cmd_driver;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_op;
  logic [7:0] alu_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_op;
  logic       busy;
  logic [7:0] txn_count;
  logic       mismatch;

`ifdef ALU_CMD_DRIVER_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] op;
  } rsp_t;

  rsp_t       exp_q[$];
  int         checks;
  int         passed;
  logic [7:0] exp_txn;
  logic       force_zero;

  alu_cmd_driver #(.W(4), .LATENCY(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op),
    .busy(busy), .txn_count(txn_count), .mismatch(mismatch)
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return {4'h0, a} + {4'h0, b};
      2'b01:   return {4'h0, a} * {4'h0, b};
      2'b10:   return {4'h0, a | b};
      default: return {4'h0, a & b};
    endcase
  endfunction

  // Wrapper model: input register stage then result register stage
  logic [3:0] w_a, w_b;
  logic [1:0] w_op;
  logic [7:0] w_out;
  always @(posedge clk) begin
    if (rst) begin
      w_a <= '0; w_b <= '0; w_op <= '0; w_out <= '0;
    end else begin
      w_a <= alu_a; w_b <= alu_b; w_op <= alu_op;
      w_out <= alu_fn(w_a, w_b, w_op);
    end
  end
  assign alu_out = force_zero ? 8'h00 : w_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input logic [7:0] exp);
    int n;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(n < 50), 32'd1);
    tick();
    exp_q.push_back('{data: exp, op: op});
    cmd_valid = 1'b0;
  endtask

  task automatic recv();
    int lat;
    rsp_t e;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'd3);
    rsp_ready = 1'b1;
    if (exp_q.size() == 0) begin
      check("queue_nonempty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("rsp_data", 32'(rsp_data), 32'(e.data));
      check("rsp_op", 32'(rsp_op), 32'(e.op));
    end
    tick();
    rsp_ready = 1'b0;
    exp_txn = exp_txn + 8'd1;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("txn_count", 32'(txn_count), 32'(exp_txn));
    check("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    exp_txn = 8'd0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [3:0] ra, rb;
    logic [1:0] rop;
    logic       seen;
    checks = 0; passed = 0; exp_txn = 0; force_zero = 1'b0;
    rst = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;

    vecs[0] = '{a: 4'h9, b: 4'h7, op: 2'b00, exp: 8'h10};
    vecs[1] = '{a: 4'hF, b: 4'hF, op: 2'b01, exp: 8'hE1};
    vecs[2] = '{a: 4'hA, b: 4'h5, op: 2'b10, exp: 8'h0F};
    vecs[3] = '{a: 4'hC, b: 4'hA, op: 2'b11, exp: 8'h08};
    vecs[4] = '{a: 4'hF, b: 4'hF, op: 2'b00, exp: 8'h1E};
    vecs[5] = '{a: 4'h0, b: 4'h7, op: 2'b01, exp: 8'h00};

    do_reset(2);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_alu_a", 32'(alu_a), 32'd0);
    check("reset_txn_count", 32'(txn_count), 32'd0);
    check("reset_mismatch", 32'(mismatch), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
      recv();
    end
    check("alu_a_held", 32'(alu_a), 32'(vecs[5].a));
    check("no_mismatch_good", 32'(mismatch), 32'd0);

    // Backpressure with a new command waiting upstream
    send(4'h3, 4'h4, 2'b00, 8'h07);
    for (int n = 0; n < 10 && !rsp_valid; n++) tick();
    cmd_a = 4'h1; cmd_b = 4'h2; cmd_op = 2'b01; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_data", 32'(rsp_data), 32'h07);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_alu_a", 32'(alu_a), 32'h3);
    end
    rsp_ready = 1'b1;
    void'(exp_q.pop_front());
    tick();
    rsp_ready = 1'b0;
    exp_txn = exp_txn + 8'd1;
    check("bp_txn_count", 32'(txn_count), 32'(exp_txn));
    check("bp_alu_a_not_yet", 32'(alu_a), 32'h3);
    tick();
    check("bp_accept_busy", 32'(busy), 32'd1);
    check("bp_accept_alu_a", 32'(alu_a), 32'h1);
    exp_q.push_back('{data: 8'h02, op: 2'b01});
    cmd_valid = 1'b0;
    recv();

    // Reset one edge after acceptance drops the in-flight result
    send(4'h5, 4'h5, 2'b00, 8'h0A);
    void'(exp_q.pop_front());
    do_reset(1);
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_txn", 32'(txn_count), 32'd0);
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    check("rst_wait_no_rsp", 32'(seen), 32'd0);
    check("rst_idle_txn", 32'(txn_count), 32'd0);

    // Corrupted wrapper result is delivered as-is; checker flags it when built in
    force_zero = 1'b1;
    send(4'h3, 4'h4, 2'b00, 8'h00);
    recv();
    force_zero = 1'b0;
    check("mm_set", 32'(mismatch), 32'(EXP_MM));
    send(4'h2, 4'h3, 2'b01, 8'h06);
    recv();
    check("mm_sticky", 32'(mismatch), 32'(EXP_MM));
    do_reset(1);
    check("mm_cleared", 32'(mismatch), 32'd0);

    for (int i = 0; i < 256; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rop = 2'($urandom_range(0, 3));
      send(ra, rb, rop, alu_fn(ra, rb, rop));
      recv();
      if (i == 254) check("txn_255", 32'(txn_count), 32'd255);
    end
    check("txn_wrap", 32'(txn_count), 32'd0);
    check("wrap_no_mismatch", 32'(mismatch), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
